// File: rtl/snn_spike_encoder.sv
// snn_spike_encoder: buffers an 8-bit image and replays it for NUM_STEPS timesteps as rate-coded AER events
module snn_spike_encoder #(
  parameter int NUM_PIXELS = 256,
  parameter int PIXEL_W = 8,
  parameter int NUM_STEPS = 16,
  localparam int AW = $clog2(NUM_PIXELS),
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               PIX_WE,
  input  logic [AW-1:0]      PIX_ADDR,
  input  logic [PIXEL_W-1:0] PIX_DATA,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic               AER_VALID,
  output logic [AW-1:0]      AER_ADDR,
  output logic [SW-1:0]      AER_STEP,
  input  logic               AER_READY
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;
  state_t state;
  logic [PIXEL_W-1:0] pix [NUM_PIXELS];
  logic [PIXEL_W-1:0] acc [NUM_PIXELS];
  logic [AW-1:0] i;
  logic [SW-1:0] s;
  logic [PIXEL_W:0] sum;
  logic adv;
  // accumulator carry-out is the spike; it fires floor(p*NUM_STEPS/2^PIXEL_W) times per run
  assign sum = {1'b0, acc[i]} + {1'b0, pix[i]};
  assign adv = (state == SCAN && !sum[PIXEL_W]) || (state == EMIT && AER_READY);
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      i <= '0;
      s <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      AER_VALID <= 1'b0;
      AER_ADDR <= '0;
      AER_STEP <= '0;
      for (int k = 0; k < NUM_PIXELS; k++) begin
        pix[k] <= '0;
        acc[k] <= '0;
      end
    end else begin
      DONE <= 1'b0;
      if (state == IDLE && PIX_WE) pix[PIX_ADDR] <= PIX_DATA;
      if (state == IDLE && START) begin
        for (int k = 0; k < NUM_PIXELS; k++) acc[k] <= '0;
        i <= '0;
        s <= '0;
        BUSY <= 1'b1;
        state <= SCAN;
      end
      if (state == SCAN) begin
        acc[i] <= sum[PIXEL_W-1:0];
        if (sum[PIXEL_W]) begin
          AER_VALID <= 1'b1;
          AER_ADDR <= i;
          AER_STEP <= s;
          state <= EMIT;
        end
      end
      if (state == EMIT && AER_READY) AER_VALID <= 1'b0;
      if (state == FIN) state <= IDLE;
      // DONE is registered on entry to FIN so it is visible during the FIN cycle
      if (adv) begin
        if (i != AW'(NUM_PIXELS - 1)) begin
          i <= i + AW'(1);
          state <= SCAN;
        end else if (s != SW'(NUM_STEPS - 1)) begin
          i <= '0;
          s <= s + SW'(1);
          state <= SCAN;
        end else begin
          state <= FIN;
          BUSY <= 1'b0;
          DONE <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_snn_spike_encoder.sv
// tb_snn_spike_encoder: table vectors, corner sequences and random images checked against a rate-coding model
module tb_snn_spike_encoder;
  localparam int NP = 256;
  localparam int NS = 16;
  logic ACLK = 0, ARESETN = 0, PIX_WE = 0, START = 0, AER_READY = 1;
  logic [7:0] PIX_ADDR = 0, PIX_DATA = 0;
  logic BUSY, DONE, AER_VALID;
  logic [7:0] AER_ADDR;
  logic [3:0] AER_STEP;
  int n_pass = 0, n_total = 0;
  int img[NP];
  int exp_q[$], got_q[$];
  int busy_cyc, done_cnt, bad_stab, bad_done;
  typedef struct {int a0, d0, a1, d1, a2, d2; bit stall; int exp_ev;} vec_t;
  vec_t vecs[4];

  snn_spike_encoder dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .PIX_WE(PIX_WE), .PIX_ADDR(PIX_ADDR),
    .PIX_DATA(PIX_DATA), .START(START), .BUSY(BUSY), .DONE(DONE),
    .AER_VALID(AER_VALID), .AER_ADDR(AER_ADDR), .AER_STEP(AER_STEP),
    .AER_READY(AER_READY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // a pixel spikes at step s whenever floor((s+1)p/256) exceeds floor(s*p/256)
  function automatic void build_model();
    exp_q.delete();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NP; p++)
        if ((s + 1) * img[p] / 256 > s * img[p] / 256) exp_q.push_back(s * 256 + p);
  endfunction

  task automatic do_reset();
    ARESETN = 0;
    tick();
    tick();
    ARESETN = 1;
    foreach (img[k]) img[k] = 0;
    tick();
  endtask

  task automatic write_pix(input int a, input int d);
    PIX_WE = 1;
    PIX_ADDR = 8'(a);
    PIX_DATA = 8'(d);
    tick();
    PIX_WE = 0;
    img[a] = d;
  endtask

  task automatic encode(input bit stall, input bit meddle, input bit wr, input int wa, input int wd);
    int stall_left = 0, pa = 0, budget, mism = 0;
    bit hold = 0, got_done = 0;
    got_q.delete();
    busy_cyc = 0; done_cnt = 0; bad_stab = 0; bad_done = 0;
    if (wr) begin
      PIX_WE = 1; PIX_ADDR = 8'(wa); PIX_DATA = 8'(wd); img[wa] = wd;
    end
    build_model();
    budget = NP * NS + exp_q.size() * 12 + 20;
    START = 1;
    tick();
    START = 0;
    PIX_WE = 0;
    for (int c = 0; c < budget && !got_done; c++) begin
      if (meddle && c == 40) begin PIX_WE = 1; PIX_ADDR = 8'd5; PIX_DATA = 8'd0; START = 1; end
      if (meddle && c == 41) begin PIX_WE = 0; START = 0; end
      AER_READY = !stall || stall_left == 0;
      if (stall_left > 0) stall_left--;
      if (BUSY) busy_cyc++;
      if (DONE) begin
        done_cnt++;
        got_done = 1;
        if (BUSY || AER_VALID) bad_done++;
      end
      if (hold && (AER_VALID !== 1'b1 || {AER_STEP, AER_ADDR} !== 12'(pa))) bad_stab++;
      hold = AER_VALID && !AER_READY;
      pa = int'({AER_STEP, AER_ADDR});
      if (AER_VALID && AER_READY) begin
        got_q.push_back(int'({AER_STEP, AER_ADDR}));
        if (stall) stall_left = $urandom_range(0, 10);
      end
      tick();
    end
    AER_READY = 1;
    for (int c = 0; c < 3; c++) begin
      if (DONE) done_cnt++;
      if (AER_VALID || BUSY) bad_done++;
      tick();
    end
    check("done_pulses", done_cnt, 1);
    check("event_count", got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] != exp_q[k]) mism++;
    check("event_order", mism, 0);
    check("payload_stable", bad_stab, 0);
    check("done_clean", bad_done, 0);
    if (!stall) check("busy_cycles", busy_cyc, NP * NS + exp_q.size());
  endtask

  initial begin
    int c, idle_bad;
    vecs[0] = '{37, 255, 37, 255, 37, 255, 1'b0, 15};
    vecs[1] = '{0, 128, 255, 16, 100, 255, 1'b0, 24};
    vecs[2] = '{5, 200, 5, 200, 5, 200, 1'b1, 12};
    vecs[3] = '{1, 1, 2, 17, 3, 240, 1'b0, 16};

    do_reset();
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    check("reset_valid", AER_VALID, 0);
    check("reset_payload", int'({AER_STEP, AER_ADDR}), 0);

    foreach (vecs[v]) begin
      do_reset();
      write_pix(vecs[v].a0, vecs[v].d0);
      write_pix(vecs[v].a1, vecs[v].d1);
      write_pix(vecs[v].a2, vecs[v].d2);
      encode(vecs[v].stall, 0, 0, 0, 0);
      check("vec_count", got_q.size(), vecs[v].exp_ev);
    end

    // reset in the middle of a stalled event, then an unwritten buffer must stay silent
    do_reset();
    write_pix(37, 255);
    START = 1;
    tick();
    START = 0;
    AER_READY = 0;
    c = 0;
    while (!AER_VALID && c < 600) begin tick(); c++; end
    check("valid_before_reset", AER_VALID, 1);
    #2 ARESETN = 0;
    #1;
    check("async_valid", AER_VALID, 0);
    check("async_busy", BUSY, 0);
    check("async_payload", int'({AER_STEP, AER_ADDR}), 0);
    tick();
    ARESETN = 1;
    AER_READY = 1;
    foreach (img[k]) img[k] = 0;
    tick();
    encode(0, 0, 0, 0, 0);
    check("blank_busy", busy_cyc, 4096);

    // writes and START during a run are dropped
    do_reset();
    write_pix(5, 200);
    encode(0, 1, 0, 0, 0);
    check("meddle_count", got_q.size(), 12);
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (BUSY || AER_VALID) idle_bad++;
      tick();
    end
    check("no_restart", idle_bad, 0);
    encode(1, 0, 0, 0, 0);
    check("rerun_count", got_q.size(), 12);

    // same-cycle write and START uses the new pixel
    do_reset();
    encode(0, 0, 1, 9, 255);
    check("same_cycle_count", got_q.size(), 15);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int j = 0; j < 6; j++) write_pix($urandom_range(0, 255), $urandom_range(0, 255));
      encode(1, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
